// File: rtl/bcd_scan_controller.sv
// Two-requester front end for one shared binary-to-BCD converter. Results are kept
// per channel and shown on a scanned 3-digit display with optional leading-zero blanking.
module bcd_scan_controller #(
    parameter int SCAN_DIV = 1000,
    parameter bit BLANK    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    input  logic       show,
    output logic       busy,
    output logic [1:0] done,
    output logic [2:0] digit_en,
    output logic [3:0] digit_val
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t           state_q;
    logic             lg_q;
    logic             owner_q;
    logic [7:0]       op_q;
    logic [9:0]       res_q [2];
    logic [1:0]       done_q;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [1:0]       idx_q, idx_d;

    logic             xfer;
    logic             grant_ch;
    logic [17:0]      dd;
    logic [9:0]       conv_bcd;
    logic [9:0]       disp;

    // A tie goes to the channel that was not granted last.
    always_comb begin
        req_ready = 2'b00;
        if (state_q == IDLE) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = lg_q ? 2'b01 : 2'b10;
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign xfer     = |(req_valid & req_ready);
    assign grant_ch = req_ready[1];

    // Shift-and-add-3 conversion; the hundreds digit never exceeds 2 so needs no correction.
    always_comb begin
        dd = {10'd0, op_q};
        for (int i = 0; i < 8; i++) begin
            if (dd[11:8] >= 4'd5)  dd[11:8]  = dd[11:8] + 4'd3;
            if (dd[15:12] >= 4'd5) dd[15:12] = dd[15:12] + 4'd3;
            dd = dd << 1;
        end
    end

    assign conv_bcd = dd[17:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lg_q     <= 1'b1;
            owner_q  <= 1'b0;
            op_q     <= 8'd0;
            res_q[0] <= 10'd0;
            res_q[1] <= 10'd0;
            done_q   <= 2'b00;
        end else begin
            done_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        op_q    <= grant_ch ? req_data1 : req_data0;
                        owner_q <= grant_ch;
                        lg_q    <= grant_ch;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    res_q[owner_q] <= conv_bcd;
                    done_q         <= owner_q ? 2'b10 : 2'b01;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == CONV);
    assign done = done_q;

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == CNT_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    assign disp = show ? res_q[1] : res_q[0];

    // digit_val stays driven even when the strobe is blanked.
    always_comb begin
        digit_val = 4'd0;
        digit_en  = 3'b000;
        case (idx_q)
            2'd0: begin
                digit_val = disp[3:0];
                digit_en  = 3'b001;
            end
            2'd1: begin
                digit_val = disp[7:4];
                digit_en  = (BLANK && disp[9:8] == 2'd0 && disp[7:4] == 4'd0) ? 3'b000 : 3'b010;
            end
            2'd2: begin
                digit_val = {2'b00, disp[9:8]};
                digit_en  = (BLANK && disp[9:8] == 2'd0) ? 3'b000 : 3'b100;
            end
            default: begin
                digit_val = 4'd0;
                digit_en  = 3'b000;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_scan_controller.sv
// Bench for bcd_scan_controller: two instances (scan 3 with blanking, scan 1 without)
// share stimulus and are compared every cycle against a decimal-arithmetic model.
module tb_bcd_scan_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [7:0] req_data0, req_data1;
    logic       show;

    logic [1:0] a_req_ready, b_req_ready;
    logic       a_busy, b_busy;
    logic [1:0] a_done, b_done;
    logic [2:0] a_digit_en, b_digit_en;
    logic [3:0] a_digit_val, b_digit_val;

    always #5 clk = ~clk;

    bcd_scan_controller #(.SCAN_DIV(3), .BLANK(1'b1)) dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(a_req_ready),
        .req_data0(req_data0), .req_data1(req_data1), .show(show), .busy(a_busy),
        .done(a_done), .digit_en(a_digit_en), .digit_val(a_digit_val)
    );

    bcd_scan_controller #(.SCAN_DIV(1), .BLANK(1'b0)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_req_ready),
        .req_data0(req_data0), .req_data1(req_data1), .show(show), .busy(b_busy),
        .done(b_done), .digit_en(b_digit_en), .digit_val(b_digit_val)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: results kept as plain integers, scan position from a cycle count.
    bit m_conv;
    int m_lg, m_owner, m_op, m_done, m_cycles;
    int m_res[2];
    bit checks_on = 1'b0;

    int samp_a_ready, samp_a_en, samp_a_val, samp_a_done, samp_b_en, samp_b_val;

    typedef struct {
        int ch;
        int data;
        int h;
        int t;
        int u;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_conv   = 1'b0;
        m_lg     = 1;
        m_owner  = 0;
        m_op     = 0;
        m_res[0] = 0;
        m_res[1] = 0;
        m_done   = 0;
        m_cycles = 0;
    endtask

    task automatic exp_disp(input int v, input int idx, input bit blank, output int en, output int val);
        int h, t, u;
        h   = v / 100;
        t   = (v / 10) % 10;
        u   = v % 10;
        val = (idx == 0) ? u : (idx == 1) ? t : h;
        en  = 1 << idx;
        if (blank && idx == 2 && h == 0) en = 0;
        if (blank && idx == 1 && h == 0 && t == 0) en = 0;
    endtask

    task automatic tick();
        int rdy, v, en, val, ch_x, d0, d1, nd;
        bit xfer, rst_now;
        @(negedge clk);
        rdy = 0;
        if (!m_conv) begin
            if (req_valid == 2'b01) rdy = 1;
            else if (req_valid == 2'b10) rdy = 2;
            else if (req_valid == 2'b11) rdy = 1 << (1 - m_lg);
        end
        samp_a_ready = a_req_ready;
        samp_a_en    = a_digit_en;
        samp_a_val   = a_digit_val;
        samp_a_done  = a_done;
        samp_b_en    = b_digit_en;
        samp_b_val   = b_digit_val;
        if (checks_on) begin
            chk("req_ready", a_req_ready, rdy);
            chk("busy", a_busy, m_conv);
            chk("done", a_done, m_done);
            chk("b_done", b_done, m_done);
            v = show ? m_res[1] : m_res[0];
            exp_disp(v, (m_cycles / 3) % 3, 1'b1, en, val);
            chk("a_digit_en", a_digit_en, en);
            chk("a_digit_val", a_digit_val, val);
            exp_disp(v, m_cycles % 3, 1'b0, en, val);
            chk("b_digit_en", b_digit_en, en);
            chk("b_digit_val", b_digit_val, val);
        end
        xfer    = (rdy & int'(req_valid)) != 0;
        ch_x    = (rdy == 2) ? 1 : 0;
        d0      = req_data0;
        d1      = req_data1;
        rst_now = reset;
        @(posedge clk);
        if (rst_now) begin
            model_reset();
        end else begin
            nd = 0;
            if (m_conv) begin
                m_res[m_owner] = m_op;
                nd = 1 << m_owner;
                m_conv = 1'b0;
            end else if (xfer) begin
                m_op    = ch_x ? d1 : d0;
                m_owner = ch_x;
                m_lg    = ch_x;
                m_conv  = 1'b1;
            end
            m_done = nd;
            m_cycles++;
        end
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        tick();
        reset = 1'b0;
    endtask

    // Push one value through a channel, then read all three digits from the unblanked instance.
    task automatic convert_and_read(input int ch, input int data, output int h, output int t, output int u);
        req_valid = (ch == 1) ? 2'b10 : 2'b01;
        if (ch == 1) req_data1 = 8'(data);
        else req_data0 = 8'(data);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        show = ch[0];
        h = -1; t = -1; u = -1;
        for (int k = 0; k < 3; k++) begin
            tick();
            case (samp_b_en)
                1: u = samp_b_val;
                2: t = samp_b_val;
                4: h = samp_b_val;
                default: ;
            endcase
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int h, t, u, n, prev;
        int pat_en[9];
        int pat_val[9];

        tbl[0] = '{0, 255, 2, 5, 5};
        tbl[1] = '{1, 7,   0, 0, 7};
        tbl[2] = '{0, 100, 1, 0, 0};
        tbl[3] = '{1, 99,  0, 9, 9};
        tbl[4] = '{0, 42,  0, 4, 2};
        tbl[5] = '{1, 10,  0, 1, 0};
        pat_en  = '{1, 1, 1, 2, 2, 2, 0, 0, 0};
        pat_val = '{9, 9, 9, 9, 9, 9, 0, 0, 0};

        reset     = 1'b1;
        req_valid = 2'b00;
        req_data0 = 8'd0;
        req_data1 = 8'd0;
        show      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks_on = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_digit_en", a_digit_en, 1);
        chk("rst_digit_val", a_digit_val, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);

        for (int i = 0; i < 6; i++) begin
            convert_and_read(tbl[i].ch, tbl[i].data, h, t, u);
            chk("tbl_h", h, tbl[i].h);
            chk("tbl_t", t, tbl[i].t);
            chk("tbl_u", u, tbl[i].u);
        end

        // Tie after reset: channel 0 first, channel 1 two cycles later.
        do_reset();
        req_valid = 2'b11;
        req_data0 = 8'd100;
        req_data1 = 8'd7;
        chk("tie_first", a_req_ready, 1);
        tick();
        req_valid = 2'b10;
        chk("tie_conv_ready", a_req_ready, 0);
        tick();
        chk("tie_second", a_req_ready, 2);
        tick();
        req_valid = 2'b00;
        repeat (2) tick();
        show = 1'b0;
        repeat (9) tick();
        show = 1'b1;
        repeat (9) tick();

        // Continuous tie: grants must alternate.
        req_valid = 2'b11;
        n = 0;
        prev = -1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (samp_a_ready != 0) begin
                if (prev >= 0) chk("alternate", samp_a_ready, prev ^ 3);
                prev = samp_a_ready;
                n++;
            end
        end
        chk("alt_grants", n, 4);
        req_valid = 2'b00;
        repeat (2) tick();

        // 99 on channel 1 with blanking, 3-cycle digits.
        convert_and_read(1, 99, h, t, u);
        show = 1'b1;
        for (int k = 0; k < 9 && (m_cycles % 9) != 0; k++) tick();
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("scan99_en", samp_a_en, pat_en[k]);
            chk("scan99_val", samp_a_val, pat_val[k]);
        end

        // Full sweep through channel 0.
        do_reset();
        for (int v = 0; v < 256; v++) begin
            convert_and_read(0, v, h, t, u);
            chk("sweep_h", h, v / 100);
            chk("sweep_t", t, (v / 10) % 10);
            chk("sweep_u", u, v % 10);
        end

        // Reset landing on the conversion cycle.
        do_reset();
        req_valid = 2'b01;
        req_data0 = 8'd42;
        tick();
        req_valid = 2'b00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 2'b01;
        chk("rc_busy", a_busy, 0);
        chk("rc_ready", a_req_ready, 1);
        chk("rc_done", a_done, 0);
        req_valid = 2'b00;
        show = 1'b0;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (samp_a_done != 0) n++;
        end
        chk("rc_no_done", n, 0);

        // Valid dropped after one cycle: exactly one capture.
        req_valid = 2'b01;
        req_data0 = 8'd33;
        tick();
        req_valid = 2'b00;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (samp_a_done != 0) n++;
        end
        chk("drop_done_count", n, 1);

        // Random traffic.
        for (int k = 0; k < 500; k++) begin
            reset     = ($urandom_range(0, 99) == 0);
            req_valid = 2'($urandom_range(0, 3));
            req_data0 = 8'($urandom_range(0, 255));
            req_data1 = 8'($urandom_range(0, 255));
            show      = 1'($urandom_range(0, 1));
            tick();
        end
        reset = 1'b0;
        req_valid = 2'b00;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
